hazard_fwd_ctl: RTL and testbench

HAZARD_FWD_CTL -- requirements
Module: hazard_fwd_ctl

---
 rtl/hazard_fwd_ctl.sv | 126 ++++++++++++
 tb/tb_hazard_fwd_ctl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctl.sv
// rtl/hazard_fwd_ctl.sv - pipeline hazard detection, forwarding select and mult/div busy tracker
// Optional stall_count performance counter is built when HAZARD_PERF_CNT_EN is defined.
module hazard_fwd_ctl #(
    parameter int REGBITS    = 5,
    parameter int MD_LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [REGBITS-1:0] rs_d,
    input  logic [REGBITS-1:0] rt_d,
    input  logic [REGBITS-1:0] rs_e,
    input  logic [REGBITS-1:0] rt_e,
    input  logic [REGBITS-1:0] writereg_e,
    input  logic [REGBITS-1:0] writereg_m,
    input  logic [REGBITS-1:0] writereg_w,
    input  logic               regwrite_e,
    input  logic               regwrite_m,
    input  logic               regwrite_w,
    input  logic               memtoreg_e,
    input  logic               memtoreg_m,
    input  logic               branch_d,
    input  logic               md_start_e,
    input  logic               md_use_d,
    output logic [1:0]         forward_ae,
    output logic [1:0]         forward_be,
    output logic               forward_ad,
    output logic               forward_bd,
    output logic               stall_f,
    output logic               stall_d,
    output logic               flush_e,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]        stall_count,
`endif
    output logic               md_busy
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lwstall, branchstall, mdstall, stall_any;

    // Register zero is hardwired, so it never takes a forwarded value.
    always_comb begin
        forward_ae = 2'b00;
        forward_be = 2'b00;
        if (rs_e != '0 && regwrite_m && writereg_m == rs_e)
            forward_ae = 2'b10;
        else if (rs_e != '0 && regwrite_w && writereg_w == rs_e)
            forward_ae = 2'b01;
        if (rt_e != '0 && regwrite_m && writereg_m == rt_e)
            forward_be = 2'b10;
        else if (rt_e != '0 && regwrite_w && writereg_w == rt_e)
            forward_be = 2'b01;
    end

    assign forward_ad = (rs_d != '0) && regwrite_m && (writereg_m == rs_d);
    assign forward_bd = (rt_d != '0) && regwrite_m && (writereg_m == rt_d);

    assign lwstall     = memtoreg_e && ((rt_e == rs_d) || (rt_e == rt_d));
    assign branchstall = branch_d &&
                         ((regwrite_e && ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
                          (memtoreg_m && ((writereg_m == rs_d) || (writereg_m == rt_d))));
    assign mdstall     = md_busy && md_use_d;
    assign stall_any   = lwstall || branchstall || mdstall;

    assign stall_f = stall_any;
    assign stall_d = stall_any;
    assign flush_e = stall_any;

    // New issues are accepted only from IDLE; BUSY ignores md_start_e entirely.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start_e) begin
                    state_d = BUSY;
                    cnt_d   = 4'(MD_LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy = (state_q == BUSY);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_d && stall_count_q != 32'hFFFF_FFFF)
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_count_q <= 32'd0;
        else
            stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctl.sv
// tb/tb_hazard_fwd_ctl.sv - self-checking bench for hazard_fwd_ctl against a behavioural model
module tb_hazard_fwd_ctl;
    localparam int RB  = 5;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [RB-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic          regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m, branch_d;
    logic          md_start_e, md_use_d;
    logic [1:0]    forward_ae, forward_be;
    logic          forward_ad, forward_bd, stall_f, stall_d, flush_e, md_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_count;
    longint        pc_model;
`endif

    int total  = 0;
    int passed = 0;
    int md_rem = 0;   // cycles of busy left in the reference model

    logic [9:0] dut_vec;
    assign dut_vec = {forward_ae, forward_be, forward_ad, forward_bd, stall_f, stall_d, flush_e, md_busy};

    always #5 clk = ~clk;

    hazard_fwd_ctl #(.REGBITS(RB), .MD_LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m), .branch_d(branch_d),
        .md_start_e(md_start_e), .md_use_d(md_use_d),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .forward_ad(forward_ad), .forward_bd(forward_bd),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
`ifdef HAZARD_PERF_CNT_EN
        .stall_count(stall_count),
`endif
        .md_busy(md_busy)
    );

    function automatic logic [1:0] fwd_code(input logic [RB-1:0] r);
        if (r == 0) return 2'b00;
        if (regwrite_m && writereg_m == r) return 2'b10;
        if (regwrite_w && writereg_w == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [9:0] model();
        logic busy, lw, br, st;
        busy = (md_rem > 0);
        lw = memtoreg_e && (rt_e == rs_d || rt_e == rt_d);
        br = branch_d && ((regwrite_e && (writereg_e == rs_d || writereg_e == rt_d)) ||
                          (memtoreg_m && (writereg_m == rs_d || writereg_m == rt_d)));
        st = lw || br || (busy && md_use_d);
        return {fwd_code(rs_e), fwd_code(rt_e),
                (rs_d != 0) && regwrite_m && writereg_m == rs_d,
                (rt_d != 0) && regwrite_m && writereg_m == rt_d,
                st, st, st, busy};
    endfunction

    task automatic clear_inputs();
        {rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w} = '0;
        {regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m, branch_d} = '0;
        md_start_e = 1'b0;
        md_use_d   = 1'b0;
    endtask

    // Advance one clock: model sees the inputs held across the edge, then return at the negedge.
    task automatic tick();
`ifdef HAZARD_PERF_CNT_EN
        logic [9:0] e;
        e = model();
`endif
        @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
        if (reset_n && e[2] && pc_model < 64'hFFFF_FFFF) pc_model++;
        if (!reset_n) pc_model = 0;
`endif
        if (!reset_n)        md_rem = 0;
        else if (md_rem > 0) md_rem--;
        else if (md_start_e) md_rem = LAT;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        md_start_e = 1'b1;
        #1;
        total++;
        if (dut_vec !== 10'b0) $display("FAIL reset_outputs actual=%b required=%b", dut_vec, 10'b0);
        else passed++;
        tick();
        total++;
        if (md_busy !== 1'b0) $display("FAIL reset_md_busy actual=%b required=0", md_busy);
        else passed++;
        // Forwarding stays purely combinational while reset is held.
        md_start_e = 1'b0;
        rs_e = 5'd5; regwrite_m = 1'b1; writereg_m = 5'd5;
        #1;
        total++;
        if (forward_ae !== 2'b10) $display("FAIL reset_comb_fwd actual=%b required=10", forward_ae);
        else passed++;
`ifdef HAZARD_PERF_CNT_EN
        pc_model = 0;
        total++;
        if (stall_count !== 32'd0) $display("FAIL reset_stall_count actual=%0d required=0", stall_count);
        else passed++;
`endif
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forwarding();
        clear_inputs();
        rs_e = 5'd5; regwrite_m = 1'b1; writereg_m = 5'd5; regwrite_w = 1'b1; writereg_w = 5'd5;
        #1;
        total++;
        if (forward_ae !== 2'b10) $display("FAIL fwd_mem_priority actual=%b required=10", forward_ae);
        else passed++;
        regwrite_m = 1'b0;
        #1;
        total++;
        if (forward_ae !== 2'b01) $display("FAIL fwd_from_wb actual=%b required=01", forward_ae);
        else passed++;
        clear_inputs();
        rs_e = 5'd0; writereg_m = 5'd0; regwrite_m = 1'b1; rt_d = 5'd0;
        #1;
        total++;
        if (forward_ae !== 2'b00) $display("FAIL fwd_r0_ae actual=%b required=00", forward_ae);
        else passed++;
        total++;
        if (forward_bd !== 1'b0) $display("FAIL fwd_r0_bd actual=%b required=0", forward_bd);
        else passed++;
        for (int i = 0; i < 200; i++) begin
            rs_e = RB'($urandom_range(0, 3)); rt_e = RB'($urandom_range(0, 3));
            rs_d = RB'($urandom_range(0, 3)); rt_d = RB'($urandom_range(0, 3));
            writereg_m = RB'($urandom_range(0, 3)); writereg_w = RB'($urandom_range(0, 3));
            regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
            #1;
            total++;
            if (dut_vec !== model() || forward_be === 2'b11)
                $display("FAIL fwd_random[%0d] actual=%b required=%b", i, dut_vec, model());
            else passed++;
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_stalls();
        clear_inputs();
        memtoreg_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8; rt_d = 5'd3;
        #1;
        total++;
        if ({stall_f, stall_d, flush_e} !== 3'b111)
            $display("FAIL lwstall_set actual=%b required=111", {stall_f, stall_d, flush_e});
        else passed++;
        memtoreg_e = 1'b0;
        #1;
        total++;
        if ({stall_f, stall_d, flush_e} !== 3'b000)
            $display("FAIL lwstall_clear actual=%b required=000", {stall_f, stall_d, flush_e});
        else passed++;
        clear_inputs();
        branch_d = 1'b1; rt_d = 5'd9; rs_d = 5'd2; regwrite_e = 1'b1; writereg_e = 5'd9;
        #1;
        total++;
        if (stall_d !== 1'b1) $display("FAIL branchstall_e actual=%b required=1", stall_d);
        else passed++;
        regwrite_e = 1'b0; writereg_e = 5'd0;
        writereg_m = 5'd9; regwrite_m = 1'b1; memtoreg_m = 1'b0;
        #1;
        total++;
        if ({stall_d, forward_bd} !== 2'b01)
            $display("FAIL branch_fwd_mem actual=%b required=01", {stall_d, forward_bd});
        else passed++;
        for (int i = 0; i < 200; i++) begin
            rs_e = RB'($urandom_range(0, 3)); rt_e = RB'($urandom_range(0, 3));
            rs_d = RB'($urandom_range(0, 3)); rt_d = RB'($urandom_range(0, 3));
            writereg_e = RB'($urandom_range(0, 3)); writereg_m = RB'($urandom_range(0, 3));
            writereg_w = RB'($urandom_range(0, 3));
            {regwrite_e, regwrite_m, regwrite_w} = 3'($urandom);
            {memtoreg_e, memtoreg_m, branch_d}   = 3'($urandom);
            #1;
            total++;
            if (dut_vec !== model())
                $display("FAIL stall_random[%0d] actual=%b required=%b", i, dut_vec, model());
            else passed++;
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_md_tracker();
        logic exp_busy [6];
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        clear_inputs();
        md_use_d   = 1'b1;
        md_start_e = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            md_start_e = (k == 1);   // second issue lands on edge 2, mid-busy
            total++;
            if ({md_busy, stall_d} !== {exp_busy[k], exp_busy[k]})
                $display("FAIL md_window_edge%0d actual=%b required=%b", k, {md_busy, stall_d},
                         {exp_busy[k], exp_busy[k]});
            else passed++;
        end
        // Issue exactly on the BUSY->IDLE edge must be dropped.
        md_start_e = 1'b1;
        tick();
        md_start_e = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        md_start_e = 1'b1;
        tick();
        md_start_e = 1'b0;
        total++;
        if (md_busy !== 1'b0) $display("FAIL md_start_at_end actual=%b required=0", md_busy);
        else passed++;
        for (int i = 0; i < 300; i++) begin
            md_start_e = ($urandom_range(0, 4) == 0);
            md_use_d   = 1'($urandom);
            rs_d = RB'($urandom_range(0, 3)); rt_e = RB'($urandom_range(0, 3));
            memtoreg_e = ($urandom_range(0, 7) == 0);
            #1;
            total++;
            if (dut_vec !== model())
                $display("FAIL md_random[%0d] actual=%b required=%b", i, dut_vec, model());
            else passed++;
`ifdef HAZARD_PERF_CNT_EN
            total++;
            if (stall_count !== 32'(pc_model))
                $display("FAIL stall_count[%0d] actual=%0d required=%0d", i, stall_count, pc_model);
            else passed++;
`endif
            tick();
        end
        clear_inputs();
        for (int k = 0; k < LAT + 1; k++) tick();
    endtask

    task automatic test_reset_mid_busy();
        clear_inputs();
        md_start_e = 1'b1;
        tick();
        md_start_e = 1'b0;
        tick();
        @(posedge clk);
        md_rem = md_rem - 1;
        #1;
        reset_n = 1'b0;
        md_rem  = 0;
        #1;
        total++;
        if (md_busy !== 1'b0) $display("FAIL reset_mid_busy actual=%b required=0", md_busy);
        else passed++;
`ifdef HAZARD_PERF_CNT_EN
        pc_model = 0;
        total++;
        if (stall_count !== 32'd0) $display("FAIL reset_mid_count actual=%0d required=0", stall_count);
        else passed++;
`endif
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            total++;
            if (md_busy !== 1'b0) $display("FAIL post_reset_idle[%0d] actual=%b required=0", k, md_busy);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_stalls();
        test_md_tracker();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
